// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, keeps at most one imem request
// in flight, hands fetched words to decode and applies redirects.
module fetch_sequencer #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] boot_addr,
  input  logic            start,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_fault,
  output logic            misaligned_fault,
  output logic [XLEN-1:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP, S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic            fault_q, fault_d;
  logic            out_q, out_d;
  logic            mis_q, mis_d;

  logic hs;      // request handshake this cycle
  logic rsp_ok;  // response that belongs to our outstanding request

  assign hs     = (state_q == S_REQ) && imem_req_ready;
  assign rsp_ok = imem_rsp_valid && out_q;

  // Next-state, PC and fetch-buffer update; redirect overrides the normal flow.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifpc_d  = ifpc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    out_d   = out_q;
    mis_d   = 1'b0;

    // Any response for the outstanding request retires it, whatever the state.
    if (hs)     out_d = 1'b1;
    if (rsp_ok) out_d = 1'b0;

    unique case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ:  if (hs) state_d = S_WAIT;
      S_WAIT: begin
        if (rsp_ok) begin
          instr_d = imem_rsp_err ? '0 : imem_rsp_data;
          ifpc_d  = pc_q;
          fault_d = imem_rsp_err;
          pc_d    = pc_q + XLEN'(4);
          state_d = S_HOLD;
        end
      end
      S_HOLD: if (if_ready) state_d = fault_q ? S_HALT : S_REQ;
      S_DROP: if (rsp_ok) state_d = S_REQ;
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid && (state_q != S_IDLE)) begin
      pc_d = redirect_addr;
      if (redirect_addr[1:0] != 2'b00) begin
        mis_d   = 1'b1;
        state_d = S_HALT;
      end else begin
        unique case (state_q)
          S_REQ:  state_d = hs ? S_DROP : S_REQ;
          S_WAIT: state_d = rsp_ok ? S_REQ : S_DROP;
          S_HOLD: state_d = S_REQ;
          // A response may still be owed (HALT drains silently); wait for it
          // before issuing so only one request is ever in flight.
          S_DROP, S_HALT: state_d = out_d ? S_DROP : S_REQ;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= boot_addr;
      ifpc_q  <= '0;
      instr_q <= '0;
      fault_q <= 1'b0;
      out_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifpc_q  <= ifpc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      out_q   <= out_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_req_valid   = (state_q == S_REQ);
  assign imem_req_addr    = pc_q;
  assign if_valid         = (state_q == S_HOLD);
  assign if_instr         = instr_q;
  assign if_pc            = ifpc_q;
  assign if_fault         = fault_q && (state_q == S_HOLD);
  assign misaligned_fault = mis_q;
  assign pc               = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: an imem model with random latency and
// a program-order scoreboard (expected next PC) checks every request and
// every instruction handed to decode.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, redirect_valid, imem_req_valid, imem_req_ready;
  logic        imem_rsp_valid, imem_rsp_err, if_valid, if_ready, if_fault;
  logic        misaligned_fault;
  logic [31:0] boot_addr, redirect_addr, imem_req_addr, imem_rsp_data;
  logic [31:0] if_instr, if_pc, pc;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .boot_addr(boot_addr), .start(start),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_fault(if_fault), .misaligned_fault(misaligned_fault),
    .pc(pc)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic errf(input logic [31:0] a);
    return a[8:2] == 7'h2B;
  endfunction

  // reference model state
  logic [31:0] exp_pc, hp_pc, hp_in, paddr;
  bit halted, exp_mis, hold_prev, exp_v, live, pend, saw_hs, saw_zero;
  int pcnt, n_acc;

  task automatic model_clear(input logic [31:0] b);
    exp_pc = b; halted = 0; exp_mis = 0; hold_prev = 0; exp_v = 0;
    live = 0; pend = 0; pcnt = 0;
  endtask

  task automatic do_reset(input logic [31:0] b);
    @(negedge clk);
    rst = 1; boot_addr = b; start = 0; redirect_valid = 0; redirect_addr = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; imem_rsp_err = 0;
    if_ready = 0;
    @(negedge clk);
    chk("rst_pc", pc, b);
    chk("rst_reqv", imem_req_valid, 0);
    chk("rst_ifv", if_valid, 0);
    chk("rst_flt", if_fault, 0);
    chk("rst_mis", misaligned_fault, 0);
    chk("rst_ins", if_instr, 0);
    chk("rst_ifpc", if_pc, 0);
    rst = 0;
    model_clear(b);
    saw_zero = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1; imem_req_ready = 0; if_ready = 0; imem_rsp_valid = 0; redirect_valid = 0;
  endtask

  task automatic cyc(input bit rdr_en);
    bit rsp_now;
    @(negedge clk);
    // outputs resulting from the previous cycle
    chk("mis", misaligned_fault, exp_mis);
    chk("ifv", if_valid, exp_v | hold_prev);
    if (halted) chk("halt_req", imem_req_valid, 0);
    if (hold_prev) begin
      chk("hold_pc", if_pc, hp_pc);
      chk("hold_ins", if_instr, hp_in);
    end
    // drive this cycle
    start = 0;
    rsp_now = 0;
    imem_rsp_valid = 0;
    imem_rsp_data = $urandom;
    imem_rsp_err = $urandom_range(0, 1);
    if (pend) begin
      if (pcnt == 0) begin
        rsp_now = 1; pend = 0;
        imem_rsp_valid = 1; imem_rsp_data = memw(paddr); imem_rsp_err = errf(paddr);
      end else pcnt--;
    end
    if_ready = ($urandom_range(0, 3) != 0);
    imem_req_ready = ($urandom_range(0, 3) != 0);
    redirect_valid = 0;
    redirect_addr = $urandom;
    if (rdr_en && $urandom_range(0, 24) == 0) begin
      redirect_valid = 1;
      redirect_addr = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
      if ($urandom_range(0, 3) == 0) redirect_addr[1:0] = 2'($urandom_range(1, 3));
    end
    #1;
    // events of this cycle, in program order
    saw_hs = 0;
    if (if_valid && if_ready) begin
      chk("acc_pc", if_pc, exp_pc);
      chk("acc_flt", if_fault, errf(exp_pc));
      chk("acc_ins", if_instr, errf(exp_pc) ? 32'h0 : memw(exp_pc));
      if (errf(exp_pc)) halted = 1;
      if (exp_pc == 0) saw_zero = 1;
      exp_pc = exp_pc + 4;
      n_acc++;
    end
    exp_v = rsp_now && live && !redirect_valid;
    if (rsp_now) live = 0;
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_pc);
      chk("one_out", 32'(pend), 0);
      pend = 1; pcnt = $urandom_range(0, 2); paddr = imem_req_addr;
      live = 1; saw_hs = 1;
    end
    exp_mis = 0;
    if (redirect_valid) begin
      live = 0;
      if (redirect_addr[1:0] != 2'b00) begin halted = 1; exp_mis = 1; end
      else begin halted = 0; exp_pc = redirect_addr; end
    end
    hold_prev = if_valid && !if_ready && !redirect_valid;
    hp_pc = if_pc;
    hp_in = if_instr;
  endtask

  initial begin
    rst = 1; boot_addr = 32'h100; start = 0; redirect_valid = 0; redirect_addr = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; imem_rsp_err = 0;
    if_ready = 0; n_acc = 0; saw_hs = 0; saw_zero = 0;
    model_clear(32'h100);

    // main random run with redirects, misaligned targets and fetch faults
    do_reset(32'h100);
    do_start();
    repeat (3000) cyc(1);
    chk("progress", 32'(n_acc > 100), 1);

    // PC wrap from the top of the address space
    do_reset(32'hFFFF_FFFC);
    do_start();
    repeat (80) cyc(0);
    chk("wrap_zero", 32'(saw_zero), 1);

    // reset while a request is outstanding
    do_reset(32'h0000_0200);
    do_start();
    saw_hs = 0;
    for (int i = 0; i < 50 && !saw_hs; i++) cyc(0);
    chk("hs_seen", 32'(saw_hs), 1);
    do_reset(32'h0000_0040);
    @(negedge clk);
    chk("idle_reqv", imem_req_valid, 0);
    chk("idle_ifv", if_valid, 0);
    chk("idle_pc", pc, 32'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
